// File: rtl/cache_pkg.sv
// Shared definitions for the lookup-cache fill controller: FSM encoding,
// access-size codes and the field layout of the lookup data word.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4,
        RESP     = 3'd5
    } state_t;

    localparam logic [2:0] LEN_B = 3'b000;
    localparam logic [2:0] LEN_H = 3'b001;
    localparam logic [2:0] LEN_W = 3'b010;

    // LK_DIN = {len, data}; entries are keyed by length, so no sub-word merge.
    localparam int unsigned LK_DATA_LSB = 0;
    localparam int unsigned LK_DATA_W   = 32;
    localparam int unsigned LK_LEN_LSB  = 32;
    localparam int unsigned LK_LEN_W    = 3;
    localparam int unsigned LK_DIN_W    = LK_LEN_LSB + LK_LEN_W;

endpackage

// File: rtl/cache_fill_ctrl.sv
// Write-side controller for the shift-register lookup cache: probes on loads,
// fills from memory on a miss, and writes stores through to memory.
// Optional memory-wait watchdog enabled by defining CACHE_FILL_TIMEOUT_EN.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CPU_REQ,
    input  logic                CPU_WE,
    input  logic [31:0]         CPU_ADDR,
    input  logic [2:0]          CPU_LEN,
    input  logic [31:0]         CPU_WDATA,
    output logic [31:0]         CPU_RDATA,
    output logic                CPU_DONE,
    output logic                CPU_BUSY,
    output logic                CPU_ERR,
    output logic [31:0]         LK_ADDR,
    output logic [LK_DIN_W-1:0] LK_DIN,
    output logic                LK_WE,
    input  logic                LK_FOUND,
    input  logic [31:0]         LK_DOUT,
    output logic                MEM_VALID,
    input  logic                MEM_READY,
    output logic                MEM_WE,
    output logic [31:0]         MEM_ADDR,
    output logic [2:0]          MEM_LEN,
    output logic [31:0]         MEM_WDATA,
    input  logic                MEM_RVALID,
    input  logic [31:0]         MEM_RDATA
);

    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W)) begin : g_cfg_check
        $error("cache_fill_ctrl: TIMEOUT_CYCLES must be below 2**TO_W");
    end

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  len_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        busy_q;
    logic        lk_we_q;
    logic        mem_valid_q;
    logic        mem_we_q;

`ifdef CACHE_FILL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    logic            to_hit;

    // Expires on the last of TIMEOUT_CYCLES cycles spent in one wait state.
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    // NOTE: all state and outputs are flops updated with non-blocking
    // assignments; each output is set on the transition into the state that
    // owns it, so the outputs never glitch on input changes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            lk_we_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
            to_cnt      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (CPU_REQ) begin
                        addr_q <= CPU_ADDR;
                        len_q  <= CPU_LEN;
                        we_q   <= CPU_WE;
                        busy_q <= 1'b1;
                        if (CPU_WE) begin
                            data_q  <= CPU_WDATA;
                            lk_we_q <= 1'b1;
                            state   <= FILL;
                        end else begin
                            data_q <= '0;
                            state  <= LOOKUP;
                        end
                    end
                end

                LOOKUP: begin
                    if (LK_FOUND) begin
                        rdata_q <= LK_DOUT;
                        done_q  <= 1'b1;
                        state   <= RESP;
                    end else begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= we_q;
`ifdef CACHE_FILL_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                        state       <= MEM_REQ;
                    end
                end

                MEM_REQ: begin
                    if (MEM_READY) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        if (we_q) begin
                            rdata_q <= '0;
                            done_q  <= 1'b1;
                            state   <= RESP;
                        end else if (MEM_RVALID) begin
                            // Same-cycle read data: skip MEM_WAIT entirely.
                            data_q  <= MEM_RDATA;
                            rdata_q <= MEM_RDATA;
                            lk_we_q <= 1'b1;
                            state   <= FILL;
                        end else begin
`ifdef CACHE_FILL_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                            state  <= MEM_WAIT;
                        end
                    end
`ifdef CACHE_FILL_TIMEOUT_EN
                    else if (to_hit) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        done_q      <= 1'b1;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                MEM_WAIT: begin
                    if (MEM_RVALID) begin
                        data_q  <= MEM_RDATA;
                        rdata_q <= MEM_RDATA;
                        lk_we_q <= 1'b1;
                        state   <= FILL;
                    end
`ifdef CACHE_FILL_TIMEOUT_EN
                    else if (to_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                FILL: begin
                    lk_we_q <= 1'b0;
                    if (we_q) begin
                        // Write-through: memory write follows the lookup update.
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b1;
`ifdef CACHE_FILL_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                        state       <= MEM_REQ;
                    end else begin
                        done_q <= 1'b1;
                        state  <= RESP;
                    end
                end

                RESP: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
                    err_q  <= 1'b0;
`endif
                    state  <= IDLE;
                end

                default: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    lk_we_q     <= 1'b0;
                    mem_valid_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign CPU_RDATA = rdata_q;
    assign CPU_DONE  = done_q;
    assign CPU_BUSY  = busy_q;
`ifdef CACHE_FILL_TIMEOUT_EN
    assign CPU_ERR   = err_q;
`else
    assign CPU_ERR   = 1'b0;
`endif

    assign LK_ADDR = addr_q;
    assign LK_DIN[LK_LEN_LSB +: LK_LEN_W]   = len_q;
    assign LK_DIN[LK_DATA_LSB +: LK_DATA_W] = data_q;
    assign LK_WE   = lk_we_q;

    assign MEM_VALID = mem_valid_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_LEN   = len_q;
    assign MEM_WDATA = data_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: expected completions are queued when a
// request is driven and compared when CPU_DONE pulses.
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    localparam int unsigned TO_LIMIT = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_REQ, CPU_WE;
    logic [31:0] CPU_ADDR, CPU_WDATA, CPU_RDATA;
    logic [2:0]  CPU_LEN;
    logic        CPU_DONE, CPU_BUSY, CPU_ERR;
    logic [31:0] LK_ADDR, LK_DOUT;
    logic [34:0] LK_DIN;
    logic        LK_WE, LK_FOUND;
    logic        MEM_VALID, MEM_READY, MEM_WE, MEM_RVALID;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic [2:0]  MEM_LEN;

    cache_fill_ctrl #(.TIMEOUT_CYCLES(TO_LIMIT), .TO_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_LEN(CPU_LEN),
        .CPU_WDATA(CPU_WDATA), .CPU_RDATA(CPU_RDATA), .CPU_DONE(CPU_DONE),
        .CPU_BUSY(CPU_BUSY), .CPU_ERR(CPU_ERR),
        .LK_ADDR(LK_ADDR), .LK_DIN(LK_DIN), .LK_WE(LK_WE),
        .LK_FOUND(LK_FOUND), .LK_DOUT(LK_DOUT),
        .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_LEN(MEM_LEN), .MEM_WDATA(MEM_WDATA),
        .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string pfx);
        check({pfx, "_done"},   CPU_DONE,  0);
        check({pfx, "_busy"},   CPU_BUSY,  0);
        check({pfx, "_err"},    CPU_ERR,   0);
        check({pfx, "_rdata"},  CPU_RDATA, 0);
        check({pfx, "_lk_we"},  LK_WE,     0);
        check({pfx, "_lk_adr"}, LK_ADDR,   0);
        check({pfx, "_lk_din"}, LK_DIN,    0);
        check({pfx, "_mvalid"}, MEM_VALID, 0);
        check({pfx, "_mwe"},    MEM_WE,    0);
        check({pfx, "_maddr"},  MEM_ADDR,  0);
        check({pfx, "_mlen"},   MEM_LEN,   0);
        check({pfx, "_mwdata"}, MEM_WDATA, 0);
    endtask

    // Waits up to budget cycles for CPU_DONE, then compares against the scoreboard.
    task automatic wait_done(input int budget, input string tag, output int waited);
        exp_t e;
        waited = 0;
        while (!CPU_DONE && waited < budget) begin
            step();
            waited++;
        end
        check({tag, "_done_seen"}, CPU_DONE, 1);
        if (CPU_DONE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_sb: DONE observed with no pending request", tag);
            end else begin
                e = sb.pop_front();
                check({tag, "_rdata"}, CPU_RDATA, e.rdata);
                check({tag, "_err"},   CPU_ERR,   e.err);
            end
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [2:0] len, input logic [31:0] wdata);
        CPU_REQ   = 1'b1;
        CPU_WE    = we;
        CPU_ADDR  = addr;
        CPU_LEN   = len;
        CPU_WDATA = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int waited;
        int n_valid;
        int n_cyc;
        bit lk_seen;

        RST = 1'b1;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_LEN = '0; CPU_WDATA = '0;
        LK_FOUND = 1'b0; LK_DOUT = '0;
        MEM_READY = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0;
        repeat (3) step();
        check_idle_zero("reset");
        RST = 1'b0;
        step();
        check("post_reset_busy", CPU_BUSY, 0);

        // Load hit: DONE in the 3rd cycle counting the acceptance cycle as 1.
        LK_FOUND = 1'b1;
        LK_DOUT  = 32'hDEADBEEF;
        drive_req(1'b0, 32'h100, LEN_W, 32'h0);
        sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        step();
        CPU_REQ = 1'b0;
        check("hit_busy", CPU_BUSY, 1);
        check("hit_lk_addr", LK_ADDR, 32'h100);
        check("hit_lk_len", LK_DIN[34:32], LEN_W);
        check("hit_lookup_mvalid", MEM_VALID, 0);
        wait_done(5, "hit", waited);
        check("hit_latency", waited + 2, 3);
        check("hit_resp_mvalid", MEM_VALID, 0);
        step();
        check("hit_done_pulse", CPU_DONE, 0);
        check("hit_idle_busy", CPU_BUSY, 0);
        LK_FOUND = 1'b0;

        // Load miss with two READY stalls and RVALID three cycles into MEM_WAIT.
        drive_req(1'b0, 32'h200, LEN_W, 32'h0);
        sb.push_back('{rdata: 32'h12345678, err: 1'b0});
        step();
        CPU_REQ = 1'b0;
        step();
        check("miss_mvalid_1", MEM_VALID, 1);
        check("miss_maddr", MEM_ADDR, 32'h200);
        check("miss_mwe", MEM_WE, 0);
        check("miss_mlen", MEM_LEN, LEN_W);
        step();
        check("miss_mvalid_2", MEM_VALID, 1);
        step();
        MEM_READY = 1'b1;
        step();
        MEM_READY = 1'b0;
        check("miss_wait_mvalid", MEM_VALID, 0);
        check("miss_wait_lk_we", LK_WE, 0);
        step();
        step();
        MEM_RVALID = 1'b1;
        MEM_RDATA  = 32'h12345678;
        step();
        MEM_RVALID = 1'b0;
        check("miss_fill_lk_we", LK_WE, 1);
        check("miss_fill_lk_din", LK_DIN, {LEN_W, 32'h12345678});
        wait_done(4, "miss", waited);
        check("miss_fill_to_done", waited, 1);
        check("miss_resp_lk_we", LK_WE, 0);
        step();

        // Store half: lookup write first, then write-through held across 4 stalls.
        drive_req(1'b1, 32'h300, LEN_H, 32'h0000BEEF);
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        step();
        CPU_REQ = 1'b0;
        check("st_fill_lk_we", LK_WE, 1);
        check("st_fill_lk_din", LK_DIN, {LEN_H, 32'h0000BEEF});
        check("st_fill_mvalid", MEM_VALID, 0);
        step();
        check("st_req_lk_we", LK_WE, 0);
        for (int i = 0; i < 4; i++) begin
            check("st_hold_mvalid", MEM_VALID, 1);
            check("st_hold_mwe", MEM_WE, 1);
            check("st_hold_mlen", MEM_LEN, LEN_H);
            check("st_hold_mwdata", MEM_WDATA, 32'h0000BEEF);
            step();
        end
        check("st_ready_mvalid", MEM_VALID, 1);
        MEM_READY = 1'b1;
        step();
        MEM_READY = 1'b0;
        wait_done(2, "store", waited);
        check("st_done_after_ready", waited, 0);
        check("st_resp_mvalid", MEM_VALID, 0);
        step();

        // Load miss with READY and RVALID together: MEM_WAIT is skipped.
        drive_req(1'b0, 32'h400, LEN_B, 32'h0);
        sb.push_back('{rdata: 32'h000000A5, err: 1'b0});
        step();
        CPU_REQ = 1'b0;
        step();
        check("fast_mvalid", MEM_VALID, 1);
        MEM_READY  = 1'b1;
        MEM_RVALID = 1'b1;
        MEM_RDATA  = 32'h000000A5;
        step();
        MEM_READY  = 1'b0;
        MEM_RVALID = 1'b0;
        check("fast_fill_lk_we", LK_WE, 1);
        check("fast_fill_lk_din", LK_DIN, {LEN_B, 32'h000000A5});
        check("fast_fill_mvalid", MEM_VALID, 0);
        wait_done(3, "fast", waited);
        check("fast_fill_to_done", waited, 1);
        step();

        // Reset while waiting for read data; the late RVALID must be ignored.
        drive_req(1'b0, 32'h500, LEN_W, 32'h0);
        step();
        CPU_REQ = 1'b0;
        step();
        MEM_READY = 1'b1;
        step();
        MEM_READY = 1'b0;
        check("abort_wait_busy", CPU_BUSY, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_idle_zero("abort");
        MEM_RVALID = 1'b1;
        MEM_RDATA  = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_late_lk_we", LK_WE, 0);
            check("abort_late_done", CPU_DONE, 0);
            check("abort_late_busy", CPU_BUSY, 0);
        end
        MEM_RVALID = 1'b0;

        LK_FOUND = 1'b1;
        LK_DOUT  = 32'hCAFEF00D;
        drive_req(1'b0, 32'h600, LEN_W, 32'h0);
        sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
        step();
        CPU_REQ = 1'b0;
        wait_done(5, "post_abort", waited);
        check("post_abort_latency", waited + 2, 3);
        LK_FOUND = 1'b0;
        step();

`ifdef CACHE_FILL_TIMEOUT_EN
        // Watchdog: READY never arrives, so the request errors out unfilled.
        drive_req(1'b0, 32'h700, LEN_W, 32'h0);
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        step();
        CPU_REQ = 1'b0;
        step();
        n_valid = 0;
        n_cyc   = 0;
        lk_seen = 1'b0;
        while (!CPU_DONE && n_cyc < 40) begin
            if (MEM_VALID) n_valid++;
            if (LK_WE) lk_seen = 1'b1;
            step();
            n_cyc++;
        end
        wait_done(0, "timeout", waited);
        check("timeout_req_cycles", n_valid, TO_LIMIT);
        check("timeout_no_fill", lk_seen, 0);
        check("timeout_mvalid", MEM_VALID, 0);
        step();
        check("timeout_err_clear", CPU_ERR, 0);
`else
        n_valid = 0;
        n_cyc   = 0;
        lk_seen = 1'b0;
`endif

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
